// File: rtl/sync_fifo_ram.sv
// Synchronous single-clock FIFO built around a DEPTH x DATA_WIDTH storage
// array with one write port and one registered read port. Occupancy is
// tracked by an explicit word counter, so full, empty and the almost
// thresholds are plain decodes of a register. Overflow and underflow are
// sticky until a clr_err edge that does not re-trigger them.

module sync_fifo_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  rd_en,
   input  logic                  clr_err,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  q_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   typedef logic [ADDR_WIDTH:0]   cnt_t;
   typedef logic [ADDR_WIDTH-1:0] ptr_t;

   localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);
   localparam cnt_t AF_CNT    = cnt_t'(AF_LEVEL);
   localparam cnt_t AE_CNT    = cnt_t'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   ptr_t wr_ptr;
   ptr_t rd_ptr;
   cnt_t count_r;

   logic wr_accept;
   logic rd_accept;

   // Status flags are decoded straight from the registered count, so they
   // describe the FIFO as it stands before the coming edge.
   always_comb begin
      full         = (count_r == DEPTH_CNT);
      empty        = (count_r == '0);
      almost_full  = (count_r >= AF_CNT);
      almost_empty = (count_r <= AE_CNT);
      count        = count_r;
   end

   // A request is honoured only when its side has room or data; reads look
   // at the pre-edge count, so a word written this edge is never bypassed.
   always_comb begin
      wr_accept = wr_en & ~full;
      rd_accept = rd_en & ~empty;
   end

   // Storage array: written only on accepted writes and deliberately not
   // reset, since reset discards the contents logically via the pointers.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr] <= data;
      end
   end

   // Write pointer advances on accepted writes and wraps naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
      end else if (wr_accept) begin
         wr_ptr <= wr_ptr + 1'b1;
      end
   end

   // Read pointer advances on accepted reads and wraps naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
      end else if (rd_accept) begin
         rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Registered read port: q loads on an accepted read and otherwise holds,
   // while q_valid pulses for exactly the edge that popped a word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q       <= '0;
         q_valid <= 1'b0;
      end else begin
         q_valid <= rd_accept;
         if (rd_accept) begin
            q <= mem[rd_ptr];
         end
      end
   end

   // Occupancy counter: a simultaneous accepted read and write cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else begin
         case ({wr_accept, rd_accept})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky error flags: a fresh error on this edge wins over clr_err.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end

         if (rd_en && empty) begin
            underflow <= 1'b1;
         end else if (clr_err) begin
            underflow <= 1'b0;
         end
      end
   end

endmodule
